// File: rtl/issueque_int_pkg.sv
// Shared widths, queue entry layout and the CDB wake-up helper for the integer issue queue.
package issueque_int_pkg;

  localparam int unsigned IQ_DEPTH  = 4;
  localparam int unsigned IQ_DATA_W = 32;
  localparam int unsigned IQ_TAG_W  = 6;
  localparam int unsigned IQ_OP_W   = 6;
  localparam int unsigned IQ_CNT_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [IQ_OP_W-1:0]   opcode;
    logic [IQ_TAG_W-1:0]  rdtag;
    logic                 rsvalid;
    logic [IQ_TAG_W-1:0]  rstag;
    logic [IQ_DATA_W-1:0] rsdata;
    logic                 rtvalid;
    logic [IQ_TAG_W-1:0]  rttag;
    logic [IQ_DATA_W-1:0] rtdata;
  } iq_entry_t;

  function automatic int unsigned iq_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Capture a matching CDB broadcast into whichever operands are still waiting.
  function automatic iq_entry_t iq_wake(input iq_entry_t e, input logic cdb_valid,
                                        input logic [IQ_TAG_W-1:0] cdb_tag,
                                        input logic [IQ_DATA_W-1:0] cdb_data);
    iq_entry_t r;
    r = e;
    if (e.valid && cdb_valid) begin
      if (!e.rsvalid && (e.rstag == cdb_tag)) begin
        r.rsvalid = 1'b1;
        r.rsdata  = cdb_data;
      end
      if (!e.rtvalid && (e.rttag == cdb_tag)) begin
        r.rtvalid = 1'b1;
        r.rtdata  = cdb_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/issueque_int_if.sv
// Dispatch / CDB / issue handshake bundle between the integer issue queue and its neighbours.
interface issueque_int_if;
  import issueque_int_pkg::*;

  logic                 flush;
  logic                 dispatch_en;
  logic [IQ_OP_W-1:0]   dispatch_opcode;
  logic [IQ_DATA_W-1:0] dispatch_rsdata;
  logic [IQ_TAG_W-1:0]  dispatch_rstag;
  logic                 dispatch_rsvalid;
  logic [IQ_DATA_W-1:0] dispatch_rtdata;
  logic [IQ_TAG_W-1:0]  dispatch_rttag;
  logic                 dispatch_rtvalid;
  logic [IQ_TAG_W-1:0]  dispatch_rdtag;
  logic                 cdb_valid;
  logic [IQ_TAG_W-1:0]  cdb_tag;
  logic [IQ_DATA_W-1:0] cdb_data;
  logic                 issueint_equeueint_done;
  logic                 issueint_ready;
  logic [IQ_OP_W-1:0]   issueint_opcode;
  logic [IQ_DATA_W-1:0] issueint_rsdata;
  logic [IQ_DATA_W-1:0] issueint_rtdata;
  logic [IQ_TAG_W-1:0]  issueint_rdtag;
  logic                 issueque_full;
  logic [IQ_CNT_W-1:0]  issueque_count;

  modport master (
    output flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag,
           dispatch_rsvalid, dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    input  issueint_ready, issueint_opcode, issueint_rsdata, issueint_rtdata,
           issueint_rdtag, issueque_full, issueque_count
  );

  modport slave (
    input  flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag,
           dispatch_rsvalid, dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    output issueint_ready, issueint_opcode, issueint_rsdata, issueint_rtdata,
           issueint_rdtag, issueque_full, issueque_count
  );

endinterface

// File: rtl/issueque_int_entry.sv
// One issue-queue slot: storage, load/shift source select and CDB wake-up.
module issueque_int_entry
  import issueque_int_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  iq_entry_t            i_disp,
  input  iq_entry_t            i_shift_in,
  input  logic                 i_cdb_valid,
  input  logic [IQ_TAG_W-1:0]  i_cdb_tag,
  input  logic [IQ_DATA_W-1:0] i_cdb_data,
  output iq_entry_t            o_entry,
  output logic                 o_ready
);

  iq_entry_t r_entry;
  iq_entry_t w_src;
  iq_entry_t w_next;

  // Wake-up is applied after the source mux so shifted and dispatched ops see this cycle's CDB.
  always_comb begin
    w_src = r_entry;
    if (i_load) begin
      w_src = i_disp;
    end else if (i_shift) begin
      w_src = i_shift_in;
    end
    w_next = iq_wake(w_src, i_cdb_valid, i_cdb_tag, i_cdb_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry <= '0;
    end else if (i_clear) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_next;
    end
  end

  assign o_entry = r_entry;
  assign o_ready = r_entry.valid & r_entry.rsvalid & r_entry.rtvalid;

endmodule

// File: rtl/issueque_int.sv
// Collapsing integer issue queue: oldest-ready select, pop-with-shift, dispatch into first free slot.
module issueque_int
  import issueque_int_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  issueque_int_if.slave bus
);

  localparam int unsigned IDX_W = iq_idx_w(DEPTH);
  localparam int unsigned CNT_W = IQ_CNT_W;

  iq_entry_t            w_entry    [DEPTH];
  iq_entry_t            w_shift_in [DEPTH];
  logic [DEPTH-1:0]     w_ready;
  logic [DEPTH-1:0]     w_load;
  logic [DEPTH-1:0]     w_shift;
  iq_entry_t            w_disp;
  logic                 w_sel_any;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_disp_acc;
  logic [CNT_W-1:0]     w_disp_slot;
  logic [CNT_W-1:0]     r_count;
  logic [IQ_OP_W-1:0]   w_out_opcode;
  logic [IQ_DATA_W-1:0] w_out_rsdata;
  logic [IQ_DATA_W-1:0] w_out_rtdata;
  logic [IQ_TAG_W-1:0]  w_out_rdtag;

  always_comb begin
    w_disp         = '0;
    w_disp.valid   = 1'b1;
    w_disp.opcode  = bus.dispatch_opcode;
    w_disp.rdtag   = bus.dispatch_rdtag;
    w_disp.rsvalid = bus.dispatch_rsvalid;
    w_disp.rstag   = bus.dispatch_rstag;
    w_disp.rsdata  = bus.dispatch_rsdata;
    w_disp.rtvalid = bus.dispatch_rtvalid;
    w_disp.rttag   = bus.dispatch_rttag;
    w_disp.rtdata  = bus.dispatch_rtdata;
  end

  // Valid entries stay packed at the bottom, so the first free slot after pop is count - pop.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = w_sel_any & bus.issueint_equeueint_done;
  assign w_disp_acc  = bus.dispatch_en & ~w_full;
  assign w_disp_slot = r_count - CNT_W'(w_pop);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i == DEPTH - 1) begin : g_last
      assign w_shift_in[i] = '0;
    end else begin : g_mid
      assign w_shift_in[i] = w_entry[i+1];
    end

    assign w_load[i]  = w_disp_acc & (w_disp_slot == CNT_W'(i));
    assign w_shift[i] = w_pop & (w_sel_idx <= IDX_W'(i));

    issueque_int_entry u_entry (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (bus.flush),
      .i_load     (w_load[i]),
      .i_shift    (w_shift[i]),
      .i_disp     (w_disp),
      .i_shift_in (w_shift_in[i]),
      .i_cdb_valid(bus.cdb_valid),
      .i_cdb_tag  (bus.cdb_tag),
      .i_cdb_data (bus.cdb_data),
      .o_entry    (w_entry[i]),
      .o_ready    (w_ready[i])
    );
  end

  // Lowest index wins: entry 0 is always the oldest.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_sel_any && w_ready[i]) begin
        w_sel_any = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_out_opcode = '0;
    w_out_rsdata = '0;
    w_out_rtdata = '0;
    w_out_rdtag  = '0;
    if (w_sel_any) begin
      w_out_opcode = w_entry[w_sel_idx].opcode;
      w_out_rsdata = w_entry[w_sel_idx].rsdata;
      w_out_rtdata = w_entry[w_sel_idx].rtdata;
      w_out_rdtag  = w_entry[w_sel_idx].rdtag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_disp_acc) - CNT_W'(w_pop);
    end
  end

  assign bus.issueint_ready  = w_sel_any;
  assign bus.issueint_opcode = w_out_opcode;
  assign bus.issueint_rsdata = w_out_rsdata;
  assign bus.issueint_rtdata = w_out_rtdata;
  assign bus.issueint_rdtag  = w_out_rdtag;
  assign bus.issueque_full   = w_full;
  assign bus.issueque_count  = r_count;

endmodule

// File: tb/tb_issueque_int.sv
// Directed + randomized bench for issueque_int against an age-ordered queue model.
module tb_issueque_int;
  import issueque_int_pkg::*;

  localparam int unsigned D = IQ_DEPTH;

  typedef struct {
    logic [IQ_OP_W-1:0]   op;
    logic [IQ_TAG_W-1:0]  rd;
    logic                 rsv;
    logic [IQ_TAG_W-1:0]  rstag;
    logic [IQ_DATA_W-1:0] rsd;
    logic                 rtv;
    logic [IQ_TAG_W-1:0]  rttag;
    logic [IQ_DATA_W-1:0] rtd;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  issueque_int_if bus ();

  issueque_int #(.DEPTH(D)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].rsv && q[i].rtv) return i;
    return -1;
  endfunction

  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (bus.cdb_valid) begin
      if (!r.rsv && r.rstag == bus.cdb_tag) begin r.rsv = 1'b1; r.rsd = bus.cdb_data; end
      if (!r.rtv && r.rttag == bus.cdb_tag) begin r.rtv = 1'b1; r.rtd = bus.cdb_data; end
    end
    return r;
  endfunction

  // Queue semantics from the rules: flush clears; else pop oldest ready, wake all, append dispatch.
  task automatic model_step();
    bit   was_full;
    int   k;
    ent_t e;
    if (bus.flush) begin
      q.delete();
    end else begin
      was_full = (q.size() == D);
      k = first_ready();
      if (k >= 0 && bus.issueint_equeueint_done) q.delete(k);
      foreach (q[i]) q[i] = wake(q[i]);
      if (bus.dispatch_en && !was_full) begin
        e.op = bus.dispatch_opcode;   e.rd = bus.dispatch_rdtag;
        e.rsv = bus.dispatch_rsvalid; e.rstag = bus.dispatch_rstag; e.rsd = bus.dispatch_rsdata;
        e.rtv = bus.dispatch_rtvalid; e.rttag = bus.dispatch_rttag; e.rtd = bus.dispatch_rtdata;
        q.push_back(wake(e));
      end
    end
  endtask

  task automatic check_outputs();
    int k = first_ready();
    chk("ready", 64'(bus.issueint_ready), 64'(k >= 0));
    if (k >= 0) begin
      chk("opcode", 64'(bus.issueint_opcode), 64'(q[k].op));
      chk("rsdata", 64'(bus.issueint_rsdata), 64'(q[k].rsd));
      chk("rtdata", 64'(bus.issueint_rtdata), 64'(q[k].rtd));
      chk("rdtag",  64'(bus.issueint_rdtag),  64'(q[k].rd));
    end else begin
      chk("idle_out", {bus.issueint_opcode, bus.issueint_rdtag, bus.issueint_rsdata ^ bus.issueint_rtdata}, 64'd0);
    end
    chk("count", 64'(bus.issueque_count), 64'(q.size()));
    chk("full",  64'(bus.issueque_full),  64'(q.size() == D));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.issueint_ready), 64'd0);
    chk({tag, "_data"}, {bus.issueint_rsdata, bus.issueint_rtdata}, 64'd0);
    chk({tag, "_tags"}, 64'({bus.issueint_opcode, bus.issueint_rdtag}), 64'd0);
    chk({tag, "_count"}, 64'({bus.issueque_full, bus.issueque_count}), 64'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus.flush = 1'b0;        bus.dispatch_en = 1'b0;
    bus.dispatch_opcode = '0; bus.dispatch_rdtag = '0;
    bus.dispatch_rsvalid = 1'b0; bus.dispatch_rstag = '0; bus.dispatch_rsdata = '0;
    bus.dispatch_rtvalid = 1'b0; bus.dispatch_rttag = '0; bus.dispatch_rtdata = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.issueint_equeueint_done = 1'b0;
  endtask

  task automatic disp(input int op, input bit rsv, input int rstag, input logic [31:0] rsd,
                      input bit rtv, input int rttag, input logic [31:0] rtd, input int rd);
    bus.dispatch_en = 1'b1;
    bus.dispatch_opcode = IQ_OP_W'(op);  bus.dispatch_rdtag = IQ_TAG_W'(rd);
    bus.dispatch_rsvalid = rsv; bus.dispatch_rstag = IQ_TAG_W'(rstag); bus.dispatch_rsdata = rsd;
    bus.dispatch_rtvalid = rtv; bus.dispatch_rttag = IQ_TAG_W'(rttag); bus.dispatch_rtdata = rtd;
  endtask

  task automatic cdb(input bit v, input int tag, input logic [31:0] data);
    bus.cdb_valid = v; bus.cdb_tag = IQ_TAG_W'(tag); bus.cdb_data = data;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // Simple add with done held high
    disp(1, 1, 0, 32'd5, 1, 0, 32'd7, 3);
    bus.issueint_equeueint_done = 1'b1;
    cycle();
    chk("t1_ready", 64'(bus.issueint_ready), 64'd1);
    chk("t1_ops", {bus.issueint_rsdata, bus.issueint_rtdata}, {32'd5, 32'd7});
    chk("t1_rdtag", 64'(bus.issueint_rdtag), 64'd3);
    bus.dispatch_en = 1'b0;
    cycle();
    chk("t1_empty", 64'({bus.issueint_ready, bus.issueque_count}), 64'd0);

    // Younger ready op overtakes a waiting one; CDB wakes the older
    idle();
    disp(2, 0, 9, 32'd0, 1, 0, 32'd1, 4);
    cycle();
    disp(3, 1, 0, 32'h11, 1, 0, 32'h22, 5);
    cycle();
    chk("t2_B_first", 64'(bus.issueint_rdtag), 64'd5);
    idle();
    bus.issueint_equeueint_done = 1'b1;
    cdb(1, 9, 32'h1234);
    cycle();
    chk("t2_A_rdtag", 64'(bus.issueint_rdtag), 64'd4);
    chk("t2_A_rsdata", 64'(bus.issueint_rsdata), 64'h1234);
    cdb(0, 0, 0);
    cycle();

    // Dispatch bypass from a same-cycle CDB broadcast
    idle();
    disp(4, 1, 0, 32'd3, 0, 12, 32'd0, 6);
    cdb(1, 12, 32'hAA);
    cycle();
    chk("t3_ready", 64'(bus.issueint_ready), 64'd1);
    chk("t3_rtdata", 64'(bus.issueint_rtdata), 64'hAA);
    idle();
    bus.issueint_equeueint_done = 1'b1;
    cycle();

    // Fill, overflow attempt, pop + rejected dispatch
    idle();
    for (int i = 0; i < 4; i++) begin
      disp(5 + i, 1, 0, 32'(100 + i), 1, 0, 32'(200 + i), 10 + i);
      cycle();
    end
    chk("t4_full", 64'({bus.issueque_full, bus.issueque_count}), 64'h14);
    disp(9, 1, 0, 32'd1, 1, 0, 32'd1, 14);
    cycle();
    chk("t4_ignored", 64'(bus.issueque_count), 64'd4);
    disp(9, 1, 0, 32'd1, 1, 0, 32'd1, 15);
    bus.issueint_equeueint_done = 1'b1;
    cycle();
    chk("t4_count3", 64'(bus.issueque_count), 64'd3);
    chk("t4_next", 64'(bus.issueint_rdtag), 64'd11);

    // Hold with done low, then single pop and ordered drain
    idle();
    disp(20, 1, 0, 32'd9, 1, 0, 32'd8, 16);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_hold", 64'({bus.issueint_rdtag, bus.issueint_rsdata}), 64'({6'd11, 32'd101}));
    end
    bus.issueint_equeueint_done = 1'b1;
    cycle();
    chk("t5_shift", 64'({bus.issueint_rdtag, bus.issueque_count}), 64'({6'd12, 4'd3}));
    for (int i = 0; i < 3; i++) cycle();

    // Flush beats dispatch and wake-up
    idle();
    disp(1, 0, 20, 0, 1, 0, 1, 30); cycle();
    disp(2, 1, 0, 1, 1, 0, 1, 31);  cycle();
    disp(3, 1, 0, 2, 0, 21, 0, 32); cycle();
    disp(4, 0, 20, 0, 1, 0, 5, 33);
    cdb(1, 20, 32'h55);
    bus.flush = 1'b1;
    bus.issueint_equeueint_done = 1'b1;
    check_outputs();
    cycle();
    chk("t6_flush", 64'({bus.issueint_ready, bus.issueque_count}), 64'd0);

    // Asynchronous reset mid-cycle
    idle();
    disp(7, 1, 0, 32'd70, 1, 0, 32'd71, 40); cycle();
    disp(8, 1, 0, 32'd80, 1, 0, 32'd81, 41);
    model_step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    idle();
    check_outputs();

    // Randomized traffic with narrow tag space for frequent wake-ups
    for (int n = 0; n < 600; n++) begin
      disp($urandom_range(0, 63), $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom, $urandom_range(0, 63));
      bus.dispatch_en = ($urandom_range(0, 9) < 6);
      cdb($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      bus.issueint_equeueint_done = $urandom_range(0, 1) == 1;
      bus.flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();
    bus.flush = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
